fifo_stream_reader: RTL and testbench

Drain-side companion to the team's 8-bit synchronous FIFO. It issues read strobes to the FIFO read port, never while the FIFO is empty and never beyond its own buffer space. Returned bytes go into a 2-entry output buffer and are presented in FIFO order on a valid/ready byte stream with burst framing (`m_last`). Throughput is one byte per cycle when the consumer keeps `m_ready` high.

---
 rtl/fifo_stream_reader.sv | 83 ++++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Drain-side reader for the 8-bit synchronous FIFO: issues guarded read strobes,
// buffers returned bytes in a head/skid pair and presents them as a framed valid/ready stream.
module fifo_stream_reader #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] byte_count
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    logic [1:0] occ;
    logic [1:0] occ_after_pop;
    logic       inflight;
    logic [7:0] head;
    logic [7:0] skid;
    logic [7:0] beat;
    logic       pop;
    logic [2:0] claimed;

    assign m_valid       = (occ != 2'd0);
    assign m_data        = head;
    assign m_last        = m_valid && (beat == LAST_BEAT);
    assign pop           = m_valid && m_ready;
    assign occ_after_pop = occ - {1'b0, pop};

    // Slots already spoken for once this cycle's pop is taken into account;
    // a read is only issued while one of the two buffer slots remains unclaimed.
    assign claimed    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = !rst && en && !fifo_empty && (claimed < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            head       <= 8'h00;
            skid       <= 8'h00;
            beat       <= 8'd0;
            byte_count <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ_after_pop + {1'b0, inflight};

            if (pop && (occ == 2'd2)) begin
                head <= skid;
            end

            // The returning byte lands in whichever slot is free after this cycle's pop.
            if (inflight) begin
                if (occ_after_pop == 2'd0) begin
                    head <= fifo_data;
                end else begin
                    skid <= fifo_data;
                end
            end

            if (pop) begin
                beat       <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
                byte_count <= byte_count + CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (({1'b0, occ} + {2'b0, inflight}) <= 3'd2);
            assert (!(fifo_rd_en && fifo_empty));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FIFO model, queue-based scoreboard of read bytes with
// their arrival cycles, directed tables/sequences and a randomized run.
module tb_fifo_stream_reader;

    localparam int BL = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] byte_count;

    fifo_stream_reader #(.BURST_LEN(BL), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         avail;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        exp_rd;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic        exp_last;
        logic [15:0] exp_cnt;
    } vec_t;

    logic [7:0] fifo_q[$];
    ent_t       exp_q[$];
    int         pops;
    int         cyc;
    int         n_chk;
    int         n_pass;

    logic        s_rd;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic [15:0] s_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs before the edge, check against
    // the reference model, then advance the FIFO model and the scoreboard.
    task automatic step(input logic r, input logic e, input logic rdy, input logic hold);
        logic       exp_valid;
        logic       exp_pop;
        logic       exp_rd;
        logic       exp_last;
        logic       do_read;
        logic [7:0] rd_val;
        int         owned;

        rst        = r;
        en         = e;
        m_ready    = rdy;
        fifo_empty = (fifo_q.size() == 0) || hold;
        #1;
        s_rd    = fifo_rd_en;
        s_valid = m_valid;
        s_data  = m_data;
        s_last  = m_last;
        s_cnt   = byte_count;

        owned     = exp_q.size();
        exp_valid = (owned > 0) && (exp_q[0].avail <= cyc);
        exp_pop   = exp_valid && rdy;
        exp_rd    = !r && e && !fifo_empty && ((owned - int'(exp_pop)) < 2);
        exp_last  = exp_valid && ((pops % BL) == (BL - 1));

        chk("mdl_rd_en", 32'(s_rd), 32'(exp_rd));
        chk("mdl_valid", 32'(s_valid), 32'(exp_valid));
        chk("mdl_last", 32'(s_last), 32'(exp_last));
        chk("mdl_count", 32'(s_cnt), 32'(pops % 65536));
        if (exp_valid) chk("mdl_data", 32'(s_data), 32'(exp_q[0].data));
        chk("rd_while_empty", 32'(s_rd && fifo_empty), 32'(0));
        chk("occ_bound", 32'(int'(dut.occ) + int'(dut.inflight) <= 2), 32'(1));

        do_read = s_rd && (fifo_q.size() > 0);
        rd_val  = 8'hEE;
        if (do_read) rd_val = fifo_q.pop_front();

        @(posedge clk);
        if (r) begin
            exp_q.delete();
            pops = 0;
        end else begin
            if (exp_pop) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (do_read) exp_q.push_back('{data: rd_val, avail: cyc + 2});
        end
        #1;
        if (do_read) fifo_data = rd_val;
        cyc++;
        @(negedge clk);
    endtask

    vec_t tbl[11];
    int   cnt_a;
    int   cnt_b;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        pops   = 0;
        cyc    = 0;
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 16'd1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 16'd2};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b1, 16'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 16'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 16'd5};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 16'd6};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 16'd7};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd8};

        rst        = 1'b1;
        en         = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with a non-empty FIFO: no strobes.
        fifo_q = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            chk("rst_rd_en", 32'(s_rd), 32'(0));
        end
        fifo_q.delete();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_valid", 32'(s_valid), 32'(0));
        chk("rst_data", 32'(s_data), 32'(8'h00));
        chk("rst_last", 32'(s_last), 32'(0));
        chk("rst_count", 32'(s_cnt), 32'(0));

        // Single byte: empty falls at relative cycle 10.
        for (int i = 0; i < 14; i++) begin
            if (i == 10) fifo_q.push_back(8'hA5);
            step(1'b0, 1'b1, 1'b1, 1'b0);
            chk("single_rd_en", 32'(s_rd), 32'(i == 10));
            if (i == 12) begin
                chk("single_valid", 32'(s_valid), 32'(1));
                chk("single_data", 32'(s_data), 32'(8'hA5));
            end
            if (i == 13) chk("single_count", 32'(s_cnt), 32'(1));
        end

        // Streaming and framing from a clean reset.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int v = 1; v <= 8; v++) fifo_q.push_back(8'(v));
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b1, tbl[i].rdy, 1'b0);
            chk("tbl_rd_en", 32'(s_rd), 32'(tbl[i].exp_rd));
            chk("tbl_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk("tbl_data", 32'(s_data), 32'(tbl[i].exp_data));
            chk("tbl_last", 32'(s_last), 32'(tbl[i].exp_last));
            chk("tbl_count", 32'(s_cnt), 32'(tbl[i].exp_cnt));
        end
        chk("tbl_beat_end", 32'(dut.beat), 32'(0));

        // Backpressure from empty, then release.
        for (int v = 1; v <= 8; v++) fifo_q.push_back(8'(v));
        cnt_a = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (s_rd) cnt_a++;
            if (i >= 2) chk("bp_hold_data", 32'(s_data), 32'(8'h01));
        end
        chk("bp_reads", 32'(cnt_a), 32'(2));
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            if (s_valid) cnt_b++;
        end
        chk("bp_release_beats", 32'(cnt_b), 32'(8));
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);

        // en dropped right after a read: byte still delivered, no further reads.
        fifo_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("en_first_read", 32'(s_rd), 32'(1));
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (s_rd) cnt_a++;
            if (s_valid) cnt_b++;
        end
        chk("en_low_reads", 32'(cnt_a), 32'(0));
        chk("en_low_beats", 32'(cnt_b), 32'(1));

        // Reset with one byte buffered and one in flight.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_inflight", 32'(dut.inflight), 32'(1));
        step(1'b1, 1'b1, 1'b0, 1'b0);
        fifo_q.delete();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_valid", 32'(s_valid), 32'(0));
        chk("mid_rst_count", 32'(s_cnt), 32'(0));
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);

        // Randomized run with toggling empty and ready.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) fifo_q.push_back(8'($urandom));
            step(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0);
        end
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
